mem_writeback_stage: RTL and testbench

Memory/writeback stage of the 3-stage RV32I pipeline, sitting between the execute stage and the register file write port. Captures one execute-stage result per cycle, performs data-memory loads and stores over a request/grant/response handshake, aligns and extends load data, and drives the registered `writeEnableMW` / `writeAddressMW` / `writeData` triple that the register file samples on the falling clock edge. While a memory access is outstanding it back-pressures execute through `stallEX`.

---
 rtl/mw_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 63 ++++++
 rtl/mem_writeback_stage.sv | 154 +++++++++++++++
 tb/tb_mem_writeback_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// Shared types and constants for the memory/writeback stage: writeback select,
// FSM states, RV32I load/store funct3 encodings and the MW pipeline register.
package mw_pkg;

  localparam int XLEN_C = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mw_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic [XLEN_C-1:0] addr;
    logic [XLEN_C-1:0] wdata;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic              reg_write;
    logic              is_store;
  } mw_reg_t;

  // funct3 encodings 011/110/111 have no RV32I meaning and fall through to word.
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_size = SZ_BYTE;
      2'b01:   access_size = SZ_HALF;
      default: access_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment: byte enables, store lane replication,
// load lane extraction with sign/zero extension, and misalign detect/masking.
module lsu_align
  import mw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] ex_addr,
  input  logic [2:0]      ex_funct3,
  output logic            ex_misaligned,
  output logic [XLEN-1:0] ex_addr_masked,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    ex_misaligned  = 1'b0;
    ex_addr_masked = ex_addr;
    case (access_size(ex_funct3))
      SZ_HALF: begin
        ex_misaligned     = ex_addr[0];
        ex_addr_masked[0] = 1'b0;
      end
      SZ_WORD: begin
        ex_misaligned       = |ex_addr[1:0];
        ex_addr_masked[1:0] = 2'b00;
      end
      default: ;
    endcase
  end

  // Half accesses reach here with addr_lo[0] already cleared, so one shift serves both sizes.
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    byte_en = 4'b1111;
    wdata   = store_data;
    ldata   = rdata;
    case (access_size(funct3))
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{store_data[7:0]}};
        ldata   = funct3[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                            : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
        wdata   = {2{store_data[15:0]}};
        ldata   = funct3[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                            : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_writeback_stage.sv
// RV32I memory/writeback stage: data-memory handshake FSM and registered
// register-file write port. Optional MISALIGN_TRAP_EN traps misaligned accesses.
module mem_writeback_stage
  import mw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exValid,
  input  logic [XLEN-1:0] exAluResult,
  input  logic [XLEN-1:0] exStoreData,
  input  logic [XLEN-1:0] exPcPlus4,
  input  logic [4:0]      exRd,
  input  logic            exRegWrite,
  input  logic            exMemRead,
  input  logic            exMemWrite,
  input  logic [2:0]      exFunct3,
  input  logic [1:0]      exWbSel,
  output logic            stallEX,
  output logic            dmemReq,
  output logic            dmemWe,
  output logic [XLEN-1:0] dmemAddr,
  output logic [XLEN-1:0] dmemWdata,
  output logic [3:0]      dmemByteEn,
  input  logic            dmemGnt,
  input  logic            dmemRvalid,
  input  logic [XLEN-1:0] dmemRdata,
`ifdef MISALIGN_TRAP_EN
  output logic            misalignTrap,
`endif
  output logic            writeEnableMW,
  output logic [4:0]      writeAddressMW,
  output logic [XLEN-1:0] writeData
);

  mw_state_e       state_q, state_d;
  mw_reg_t         mw_q, mw_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            trap_q, trap_d;

  logic            ex_misaligned;
  logic [XLEN-1:0] ex_addr_masked;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_ldata;
  logic            mem_op;
  logic            in_req;

  lsu_align #(.XLEN(XLEN)) u_align (
    .ex_addr       (exAluResult),
    .ex_funct3     (exFunct3),
    .ex_misaligned (ex_misaligned),
    .ex_addr_masked(ex_addr_masked),
    .addr_lo       (mw_q.addr[1:0]),
    .funct3        (mw_q.funct3),
    .store_data    (mw_q.wdata),
    .rdata         (dmemRdata),
    .byte_en       (lane_be),
    .wdata         (lane_wdata),
    .ldata         (lane_ldata)
  );

  assign mem_op = exMemRead | exMemWrite;

  always_comb begin
    state_d   = state_q;
    mw_d      = mw_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    trap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exValid && mem_op) begin
          mw_d.wdata     = exStoreData;
          mw_d.funct3    = exFunct3;
          mw_d.rd        = exRd;
          mw_d.reg_write = exRegWrite;
          mw_d.is_store  = exMemWrite;
`ifdef MISALIGN_TRAP_EN
          mw_d.addr      = ex_addr_masked;
          if (ex_misaligned) begin
            mw_d   = mw_q;
            trap_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
`else
          mw_d.addr      = ex_misaligned ? ex_addr_masked : exAluResult;
          state_d        = ST_REQ;
`endif
        end else if (exValid) begin
          wb_en_d   = exRegWrite && (exRd != 5'd0);
          wb_addr_d = exRd;
          wb_data_d = (wb_sel_e'(exWbSel) == WB_PC4) ? exPcPlus4 : exAluResult;
        end
      end
      ST_REQ: begin
        if (dmemGnt) begin
          state_d = mw_q.is_store ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (dmemRvalid) begin
          wb_en_d   = mw_q.reg_write && (mw_q.rd != 5'd0);
          wb_addr_d = mw_q.rd;
          wb_data_d = lane_ldata;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mw_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mw_q      <= mw_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      trap_q    <= trap_d;
    end
  end

  // Request fields are gated by state so the bus reads all-zero outside REQ.
  assign in_req         = (state_q == ST_REQ);
  assign stallEX        = (state_q != ST_IDLE);
  assign dmemReq        = in_req;
  assign dmemWe         = in_req & mw_q.is_store;
  assign dmemAddr       = in_req ? {mw_q.addr[XLEN-1:2], 2'b00} : '0;
  assign dmemWdata      = in_req ? lane_wdata : '0;
  assign dmemByteEn     = in_req ? lane_be : 4'b0000;
  assign writeEnableMW  = wb_en_q;
  assign writeAddressMW = wb_addr_q;
  assign writeData      = wb_data_q;
`ifdef MISALIGN_TRAP_EN
  assign misalignTrap   = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Scoreboard bench for mem_writeback_stage: directed vectors push expected
// memory requests and writebacks; a negedge monitor pops and compares.
module tb_mem_writeback_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exValid = 1'b0;
  logic [31:0] exAluResult = '0, exStoreData = '0, exPcPlus4 = '0;
  logic [4:0]  exRd = '0;
  logic        exRegWrite = 1'b0, exMemRead = 1'b0, exMemWrite = 1'b0;
  logic [2:0]  exFunct3 = '0;
  logic [1:0]  exWbSel = '0;
  logic        stallEX, dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic [3:0]  dmemByteEn;
  logic        dmemGnt = 1'b0, dmemRvalid = 1'b0;
  logic [31:0] dmemRdata = '0;
  logic        writeEnableMW;
  logic [4:0]  writeAddressMW;
  logic [31:0] writeData;
`ifdef MISALIGN_TRAP_EN
  logic        misalignTrap;
`endif

  mem_writeback_stage dut (
    .clock(clock), .reset(reset), .exValid(exValid), .exAluResult(exAluResult),
    .exStoreData(exStoreData), .exPcPlus4(exPcPlus4), .exRd(exRd),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exFunct3(exFunct3), .exWbSel(exWbSel), .stallEX(stallEX),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWdata(dmemWdata), .dmemByteEn(dmemByteEn), .dmemGnt(dmemGnt),
    .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata),
`ifdef MISALIGN_TRAP_EN
    .misalignTrap(misalignTrap),
`endif
    .writeEnableMW(writeEnableMW), .writeAddressMW(writeAddressMW),
    .writeData(writeData)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (writeEnableMW) begin
        if (wb_q.size() == 0) check("unexpected_wb", 32'd1, 32'd0);
        else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          check("wb_addr", {27'd0, writeAddressMW}, {27'd0, e.rd});
          check("wb_data", writeData, e.data);
        end
      end
      if (dmemReq && dmemGnt) begin
        if (req_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
        else begin
          req_exp_t r;
          r = req_q.pop_front();
          check("req_we", {31'd0, dmemWe}, {31'd0, r.we});
          check("req_addr", dmemAddr, r.addr);
          check("req_be", {28'd0, dmemByteEn}, {28'd0, r.be});
          if (r.we) check("req_wdata", dmemWdata, r.wdata);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4);
    exValid = 1'b1; exFunct3 = f3; exRd = rd; exRegWrite = rw; exMemRead = mr;
    exMemWrite = mw; exWbSel = sel; exAluResult = alu; exStoreData = sd; exPcPlus4 = pc4;
    @(posedge clock); #1;
    exValid = 1'b0; exMemRead = 1'b0; exMemWrite = 1'b0; exRegWrite = 1'b0;
  endtask

  task automatic serve(input int gnt_delay, input bit is_load, input logic [31:0] rdata);
    for (int i = 0; i < gnt_delay; i++) begin
      @(negedge clock); check("stall_in_req", {31'd0, stallEX}, 32'd1);
      @(posedge clock); #1;
    end
    dmemGnt = 1'b1;
    @(posedge clock); #1;
    dmemGnt = 1'b0;
    if (is_load) begin
      dmemRvalid = 1'b1; dmemRdata = rdata;
      @(negedge clock); check("stall_rvalid_cycle", {31'd0, stallEX}, 32'd1);
      @(posedge clock); #1;
      dmemRvalid = 1'b0;
    end
    @(negedge clock); check("stall_released", {31'd0, stallEX}, 32'd0);
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    req_exp_t r;
    r.we = we; r.addr = a; r.be = be; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_exp_t e;
    e.rd = rd; e.data = d;
    wb_q.push_back(e);
  endtask

  initial begin
    #2;
    check("rst_stall", {31'd0, stallEX}, 32'd0);
    check("rst_req", {31'd0, dmemReq}, 32'd0);
    check("rst_we", {31'd0, writeEnableMW}, 32'd0);
    check("rst_wdata", writeData, 32'd0);
    check("rst_byteen", {28'd0, dmemByteEn}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // ALU op, one-cycle writeback pulse
    push_wb(5'd5, 32'hDEADBEEF);
    issue(3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF, 32'd0, 32'd0);
    @(negedge clock); check("alu_wbe_high", {31'd0, writeEnableMW}, 32'd1);
    @(negedge clock); check("alu_wbe_pulse", {31'd0, writeEnableMW}, 32'd0);

    // LB 0x1003, grant two cycles late
    push_req(1'b0, 32'h1000, 4'b1000, 32'd0);
    push_wb(5'd6, 32'hFFFFFF80);
    issue(3'b000, 5'd6, 1'b1, 1'b1, 1'b0, 2'd1, 32'h1003, 32'd0, 32'd0);
    serve(2, 1'b1, 32'h80112233);

    // SH 0x2002, no writeback
    push_req(1'b1, 32'h2000, 4'b1100, 32'hABCDABCD);
    issue(3'b001, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h2002, 32'h0000ABCD, 32'd0);
    serve(0, 1'b0, 32'd0);

    // SB 0x5001 and SW 0x6000
    push_req(1'b1, 32'h5000, 4'b0010, 32'hA5A5A5A5);
    issue(3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h5001, 32'h000000A5, 32'd0);
    serve(1, 1'b0, 32'd0);
    push_req(1'b1, 32'h6000, 4'b1111, 32'h11223344);
    issue(3'b010, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h6000, 32'h11223344, 32'd0);
    serve(0, 1'b0, 32'd0);

    // LHU 0x4002 and LH 0x4000
    push_req(1'b0, 32'h4000, 4'b1100, 32'd0);
    push_wb(5'd10, 32'h00008011);
    issue(3'b101, 5'd10, 1'b1, 1'b1, 1'b0, 2'd1, 32'h4002, 32'd0, 32'd0);
    serve(0, 1'b1, 32'h80112233);
    push_req(1'b0, 32'h4000, 4'b0011, 32'd0);
    push_wb(5'd11, 32'hFFFFF00F);
    issue(3'b001, 5'd11, 1'b1, 1'b1, 1'b0, 2'd1, 32'h4000, 32'd0, 32'd0);
    serve(0, 1'b1, 32'h0000F00F);

    // LW misaligned 0x3002
`ifdef MISALIGN_TRAP_EN
    issue(3'b010, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 32'h3002, 32'd0, 32'd0);
    @(negedge clock);
    check("trap_pulse", {31'd0, misalignTrap}, 32'd1);
    check("trap_no_stall", {31'd0, stallEX}, 32'd0);
    check("trap_no_req", {31'd0, dmemReq}, 32'd0);
    @(negedge clock); check("trap_clears", {31'd0, misalignTrap}, 32'd0);
`else
    push_req(1'b0, 32'h3000, 4'b1111, 32'd0);
    push_wb(5'd7, 32'h12345678);
    issue(3'b010, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 32'h3002, 32'd0, 32'd0);
    serve(0, 1'b1, 32'h12345678);
`endif

    // Reset asserted while waiting in RESP
    push_req(1'b0, 32'h7000, 4'b1111, 32'd0);
    issue(3'b010, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 32'h7000, 32'd0, 32'd0);
    dmemGnt = 1'b1;
    @(posedge clock); #1;
    dmemGnt = 1'b0;
    check("resp_stall", {31'd0, stallEX}, 32'd1);
    reset = 1'b0; #1;
    check("midrst_stall", {31'd0, stallEX}, 32'd0);
    check("midrst_req", {31'd0, dmemReq}, 32'd0);
    check("midrst_addr", dmemAddr, 32'd0);
    check("midrst_wbe", {31'd0, writeEnableMW}, 32'd0);
    check("midrst_wdata", writeData, 32'd0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    dmemRvalid = 1'b1; dmemRdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    dmemRvalid = 1'b0;
    @(negedge clock);
    check("late_rvalid_no_wb", {31'd0, writeEnableMW}, 32'd0);
    check("late_rvalid_idle", {31'd0, stallEX}, 32'd0);

    // PC+4 writeback to x0 then x1
    issue(3'b000, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h55, 32'd0, 32'h100);
    @(negedge clock); check("pc4_x0_no_wb", {31'd0, writeEnableMW}, 32'd0);
    push_wb(5'd1, 32'h104);
    issue(3'b000, 5'd1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h55, 32'd0, 32'h104);
    @(negedge clock); check("pc4_x1_wb", {31'd0, writeEnableMW}, 32'd1);
    repeat (2) @(negedge clock);

    check("wb_queue_drained", wb_q.size(), 32'd0);
    check("req_queue_drained", req_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
